// File: rtl/data_memory_responder.sv
// MEM-stage data memory: byte-addressed little-endian array with a fixed
// multi-cycle access latency, BUSYWAIT stall and alignment fault reporting.
module data_memory_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 3
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MEM_READ,
    input  logic        MEM_WRITE,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITE_DATA,
    input  logic [2:0]  FUNC3,
    output logic [31:0] READ_DATA,
    output logic        BUSYWAIT,
    output logic        ACCESS_FAULT
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t                state;
    logic [3:0]            count;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [2:0]            func3_q;
    logic                  is_store_q;

    logic [7:0] mem [DEPTH];

    logic                  request;
    logic                  fire;
    logic [1:0]            size;
    logic                  legal;
    logic                  misaligned;
    logic                  fault;
    logic [ADDR_WIDTH-1:0] idx1;
    logic [ADDR_WIDTH-1:0] idx2;
    logic [ADDR_WIDTH-1:0] idx3;
    logic [7:0]            b0;
    logic [7:0]            b1;
    logic [7:0]            b2;
    logic [7:0]            b3;
    logic [31:0]           load_val;
    logic                  unused_addr;

    // Upper address bits alias onto the array.
    assign unused_addr = ^ADDRESS[31:ADDR_WIDTH];

    assign request = MEM_READ | MEM_WRITE;
    assign fire    = (state == ACCESS) && (count == 4'd0);

    assign BUSYWAIT = !RESET &&
                      (((state == IDLE) && request) || (state == ACCESS));

    // size: 0 byte, 1 half, 2 word; unsigned forms exist only for loads.
    always_comb begin
        size  = 2'd0;
        legal = 1'b0;
        case (func3_q)
            3'b000: begin
                size  = 2'd0;
                legal = 1'b1;
            end
            3'b001: begin
                size  = 2'd1;
                legal = 1'b1;
            end
            3'b010: begin
                size  = 2'd2;
                legal = 1'b1;
            end
            3'b100: begin
                size  = 2'd0;
                legal = !is_store_q;
            end
            3'b101: begin
                size  = 2'd1;
                legal = !is_store_q;
            end
            default: begin
                size  = 2'd0;
                legal = 1'b0;
            end
        endcase
    end

    assign misaligned = ((size == 2'd1) && addr_q[0]) ||
                        ((size == 2'd2) && (addr_q[1:0] != 2'b00));
    assign fault      = !legal || misaligned;

    assign idx1 = addr_q + ADDR_WIDTH'(1);
    assign idx2 = addr_q + ADDR_WIDTH'(2);
    assign idx3 = addr_q + ADDR_WIDTH'(3);

    assign b0 = mem[addr_q];
    assign b1 = mem[idx1];
    assign b2 = mem[idx2];
    assign b3 = mem[idx3];

    always_comb begin
        load_val = {b3, b2, b1, b0};
        case (size)
            2'd0: begin
                if (func3_q[2])
                    load_val = {24'h0, b0};
                else
                    load_val = {{24{b0[7]}}, b0};
            end
            2'd1: begin
                if (func3_q[2])
                    load_val = {16'h0, b1, b0};
                else
                    load_val = {{16{b1[7]}}, b1, b0};
            end
            default: load_val = {b3, b2, b1, b0};
        endcase
    end

    // Array is never cleared; a reset at the commit edge drops the store.
    always_ff @(posedge CLK) begin
        if (!RESET && fire && is_store_q && !fault) begin
            mem[addr_q] <= wdata_q[7:0];
            if (size != 2'd0)
                mem[idx1] <= wdata_q[15:8];
            if (size == 2'd2) begin
                mem[idx2] <= wdata_q[23:16];
                mem[idx3] <= wdata_q[31:24];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= IDLE;
            count        <= 4'd0;
            READ_DATA    <= 32'h0;
            ACCESS_FAULT <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (request) begin
                        addr_q       <= ADDRESS[ADDR_WIDTH-1:0];
                        wdata_q      <= WRITE_DATA;
                        func3_q      <= FUNC3;
                        is_store_q   <= MEM_WRITE;
                        count        <= 4'(LATENCY - 1);
                        ACCESS_FAULT <= 1'b0;
                        state        <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (count == 4'd0) begin
                        ACCESS_FAULT <= fault;
                        if (!is_store_q)
                            READ_DATA <= fault ? 32'h0 : load_val;
                        state <= DONE;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: table of requests with a scoreboard queue,
// plus hand sequences for reset, input changes and reset mid-access.
module tb_data_memory_responder;

    localparam int AW  = 10;
    localparam int LAT = 3;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [31:0] ADDRESS;
    logic [31:0] WRITE_DATA;
    logic [2:0]  FUNC3;
    logic [31:0] READ_DATA;
    logic        BUSYWAIT;
    logic        ACCESS_FAULT;

    data_memory_responder #(
        .ADDR_WIDTH(AW),
        .LATENCY(LAT)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .MEM_READ(MEM_READ),
        .MEM_WRITE(MEM_WRITE),
        .ADDRESS(ADDRESS),
        .WRITE_DATA(WRITE_DATA),
        .FUNC3(FUNC3),
        .READ_DATA(READ_DATA),
        .BUSYWAIT(BUSYWAIT),
        .ACCESS_FAULT(ACCESS_FAULT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  f3;
        logic [31:0] exp_rd;
        logic        exp_fault;
    } vec_t;

    typedef struct {
        logic [31:0] rd;
        logic        fault;
    } exp_t;

    exp_t        sb[$];
    vec_t        vecs[18];
    logic [31:0] model_rd;
    int          n_cmp;
    int          n_bad;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic wr,
                                input logic [31:0] addr,
                                input logic [31:0] data,
                                input logic [2:0] f3,
                                input logic [31:0] exp_rd,
                                input logic exp_fault);
        vec_t v;
        v.rd        = rd;
        v.wr        = wr;
        v.addr      = addr;
        v.data      = data;
        v.f3        = f3;
        v.exp_rd    = exp_rd;
        v.exp_fault = exp_fault;
        return v;
    endfunction

    task automatic run_req(input vec_t v, input bit scramble,
                           input string name);
        exp_t e;
        int   busy;
        bit   done;
        @(posedge CLK);
        #1;
        MEM_READ   = v.rd;
        MEM_WRITE  = v.wr;
        ADDRESS    = v.addr;
        WRITE_DATA = v.data;
        FUNC3      = v.f3;
        if (v.rd && !v.wr) begin
            e.rd     = v.exp_rd;
            model_rd = v.exp_rd;
        end else begin
            e.rd = model_rd;
        end
        e.fault = v.exp_fault;
        sb.push_back(e);
        busy = 0;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge CLK);
            if (BUSYWAIT) begin
                busy++;
                if (scramble && busy == 2) begin
                    ADDRESS    = ~ADDRESS;
                    WRITE_DATA = 32'h0;
                end
            end else begin
                done = 1'b1;
            end
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout: BUSYWAIT never dropped", name);
        end
        check({name, " busy"}, busy, LAT + 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({name, " rdata"}, READ_DATA, e.rd);
            check({name, " fault"}, {31'h0, ACCESS_FAULT}, {31'h0, e.fault});
        end
        @(posedge CLK);
        #1;
        MEM_READ  = 1'b0;
        MEM_WRITE = 1'b0;
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        model_rd  = 32'h0;
        RESET     = 1'b1;
        MEM_READ  = 1'b1;
        MEM_WRITE = 1'b0;
        ADDRESS   = 32'h0;
        WRITE_DATA = 32'h0;
        FUNC3     = 3'b010;

        vecs[0]  = mk(0, 1, 32'h10,  32'hDEADBEEF, 3'b010, 32'h0, 0);
        vecs[1]  = mk(1, 0, 32'h10,  32'h0, 3'b010, 32'hDEADBEEF, 0);
        vecs[2]  = mk(1, 0, 32'h13,  32'h0, 3'b000, 32'hFFFFFFDE, 0);
        vecs[3]  = mk(1, 0, 32'h13,  32'h0, 3'b100, 32'h000000DE, 0);
        vecs[4]  = mk(1, 0, 32'h10,  32'h0, 3'b001, 32'hFFFFBEEF, 0);
        vecs[5]  = mk(1, 0, 32'h12,  32'h0, 3'b101, 32'h0000DEAD, 0);
        vecs[6]  = mk(0, 1, 32'h11,  32'h55, 3'b000, 32'h0, 0);
        vecs[7]  = mk(1, 0, 32'h10,  32'h0, 3'b010, 32'hDEAD55EF, 0);
        vecs[8]  = mk(1, 0, 32'h12,  32'h0, 3'b010, 32'h0, 1);
        vecs[9]  = mk(0, 1, 32'h11,  32'h1234, 3'b001, 32'h0, 1);
        vecs[10] = mk(1, 0, 32'h10,  32'h0, 3'b010, 32'hDEAD55EF, 0);
        vecs[11] = mk(1, 0, 32'h10,  32'h0, 3'b011, 32'h0, 1);
        vecs[12] = mk(0, 1, 32'h10,  32'h0, 3'b100, 32'h0, 1);
        vecs[13] = mk(1, 0, 32'h10,  32'h0, 3'b010, 32'hDEAD55EF, 0);
        vecs[14] = mk(1, 1, 32'h20,  32'hA5A5A5A5, 3'b010, 32'h0, 0);
        vecs[15] = mk(1, 0, 32'h420, 32'h0, 3'b010, 32'hA5A5A5A5, 0);
        vecs[16] = mk(0, 1, 32'h22,  32'h00007777, 3'b001, 32'h0, 0);
        vecs[17] = mk(1, 0, 32'h20,  32'h0, 3'b010, 32'h7777A5A5, 0);

        @(posedge CLK);
        @(negedge CLK);
        check("busy in reset", {31'h0, BUSYWAIT}, 32'h0);
        @(posedge CLK);
        #1;
        MEM_READ = 1'b0;
        check("reset rdata", READ_DATA, 32'h0);
        check("reset fault", {31'h0, ACCESS_FAULT}, 32'h0);
        RESET = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("idle busy", {31'h0, BUSYWAIT}, 32'h0);
        check("idle rdata", READ_DATA, 32'h0);

        for (int i = 0; i < 18; i++)
            run_req(vecs[i], 1'b0, $sformatf("vec%0d", i));

        run_req(mk(0, 1, 32'h30, 32'h11223344, 3'b010, 32'h0, 0),
                1'b1, "scramble sw");
        run_req(mk(1, 0, 32'h30, 32'h0, 3'b010, 32'h11223344, 0),
                1'b0, "scramble lw30");
        run_req(mk(1, 0, 32'h10, 32'h0, 3'b010, 32'hDEAD55EF, 0),
                1'b0, "scramble lw10");

        @(posedge CLK);
        #1;
        MEM_WRITE  = 1'b1;
        ADDRESS    = 32'h10;
        WRITE_DATA = 32'h0;
        FUNC3      = 3'b010;
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        RESET     = 1'b1;
        MEM_WRITE = 1'b0;
        @(negedge CLK);
        check("abort busy", {31'h0, BUSYWAIT}, 32'h0);
        @(posedge CLK);
        #1;
        RESET    = 1'b0;
        model_rd = 32'h0;
        check("abort rdata", READ_DATA, 32'h0);
        check("abort fault", {31'h0, ACCESS_FAULT}, 32'h0);
        run_req(mk(1, 0, 32'h10, 32'h0, 3'b010, 32'hDEAD55EF, 0),
                1'b0, "post abort lw");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
